rmt_axis_traffic_gen: RTL

Synthesisable, parametrised AXI-Stream traffic generator and loop-back checker for exercising the RMT pipeline (`rmt_wrapper`) on hardware and in simulation. The master side emits a programmable header beat followed by sequence-numbered payload beats. The optional slave-side checker verifies the pipeline output and keeps error and throughput counters. The block sits between a control/CSR shim and the pipeline's input and output AXI-Stream ports.

---
 rtl/rmt_traffic_pkg.sv | 23 ++
 rtl/rmt_traffic_checker.sv | 72 +++++++
 rtl/rmt_axis_traffic_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rmt_traffic_pkg.sv
// Shared definitions for the RMT AXI-Stream traffic generator and its loop-back checker.
package rmt_traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned SEQ_START      = 1;
  localparam int unsigned MAX_KEEP_WIDTH = 256;

  // Lower w/8 bits set; callers size-cast down to their own tkeep width.
  function automatic logic [MAX_KEEP_WIDTH-1:0] all_ones_keep(input int unsigned w);
    logic [MAX_KEEP_WIDTH-1:0] keep;
    keep = '0;
    for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
      if (i < w / 8) keep[i] = 1'b1;
    end
    return keep;
  endfunction

endpackage

// File: rtl/rmt_traffic_checker.sv
// RX-side loop-back checker: verifies sequence payload, tkeep and tlast position,
// and counts received packets and errors. Built only with RMT_TRAFFIC_CHECKER_EN.
module rmt_traffic_checker
  import rmt_traffic_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int CNT_WIDTH         = 64
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [15:0]                    rx_len,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tready,
  output logic [CNT_WIDTH-1:0]           rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]           err_cnt
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam logic [KW-1:0] KEEP_ONES = KW'(all_ones_keep(C_AXIS_DATA_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [15:0]          j_reg;
  logic [CNT_WIDTH-1:0] rx_seq_reg, exp_seq_reg, rx_pkt_cnt_reg, err_cnt_reg;

  logic                 beat, at_end, seq_err, data_err, any_err, pkt_end;
  logic [CNT_WIDTH-1:0] rx_seq_now, seq_base;

  always_comb begin
    beat       = s_axis_tvalid && s_axis_tready;
    at_end     = (j_reg == rx_len - 16'd1);
    rx_seq_now = CNT_WIDTH'(s_axis_tdata - C_AXIS_DATA_WIDTH'(1));
    seq_err    = (rx_seq_now != exp_seq_reg);
    data_err   = 1'b0;
    if (j_reg == 16'd1)
      data_err = seq_err;
    else if (j_reg >= 16'd2)
      data_err = (s_axis_tdata != C_AXIS_DATA_WIDTH'(rx_seq_reg + CNT_WIDTH'(j_reg)));
    any_err  = (s_axis_tkeep != KEEP_ONES) || (s_axis_tlast != at_end) || data_err;
    seq_base = (j_reg == 16'd1 && seq_err) ? rx_seq_now : exp_seq_reg;
    // A missing tlast still closes the packet at the expected length so one
    // dropped tlast costs exactly one error instead of cascading.
    pkt_end  = s_axis_tlast || at_end;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      j_reg          <= '0;
      rx_seq_reg     <= '0;
      exp_seq_reg    <= CNT_WIDTH'(SEQ_START);
      rx_pkt_cnt_reg <= '0;
      err_cnt_reg    <= '0;
    end else if (beat) begin
      if (any_err && err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + CNT_ONE;
      if (j_reg == 16'd1) rx_seq_reg <= rx_seq_now;
      if (pkt_end) begin
        j_reg       <= '0;
        exp_seq_reg <= seq_base + CNT_ONE;
        if (s_axis_tlast) rx_pkt_cnt_reg <= rx_pkt_cnt_reg + CNT_ONE;
      end else begin
        j_reg       <= j_reg + 16'd1;
        exp_seq_reg <= seq_base;
      end
    end
  end

  assign rx_pkt_cnt = rx_pkt_cnt_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: rtl/rmt_axis_traffic_gen.sv
// AXI-Stream traffic generator (header beat + sequence payload) for the RMT pipeline.
// Define RMT_TRAFFIC_CHECKER_EN to build the loop-back checker on the s_axis side.
module rmt_axis_traffic_gen
  import rmt_traffic_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int CNT_WIDTH          = 64
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic                            start,
  input  logic [15:0]                     pkt_len,
  input  logic [CNT_WIDTH-1:0]            num_pkts,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    hdr_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   hdr_tuser,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic                            done,
  output logic [CNT_WIDTH-1:0]            tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]            tx_byte_cnt,
  output logic [CNT_WIDTH-1:0]            cycle_cnt,
  output logic [CNT_WIDTH-1:0]            rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]            err_cnt
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam logic [KW-1:0] KEEP_ONES = KW'(all_ones_keep(C_AXIS_DATA_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state_reg, state_next;
  logic [15:0]                   len_reg, k_reg;
  logic [CNT_WIDTH-1:0]          num_reg, seq_reg;
  logic [CNT_WIDTH-1:0]          tx_pkt_cnt_reg, tx_byte_cnt_reg, cycle_cnt_reg;
  logic [C_AXIS_DATA_WIDTH-1:0]  hdr_data_reg;
  logic [C_AXIS_TUSER_WIDTH-1:0] hdr_user_reg;
  logic                          s_ready_reg;

  logic valid, last_beat, fire;

  assign valid     = (state_reg == ST_RUN);
  assign last_beat = (k_reg == len_reg - 16'd1);
  assign fire      = valid && m_axis_tready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (fire && last_beat) begin
          if (num_reg != '0 && tx_pkt_cnt_reg + CNT_ONE == num_reg) state_next = ST_DONE;
          else if (!start)                                            state_next = ST_IDLE;
        end
      end
      ST_DONE: if (!start) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= ST_IDLE;
      len_reg         <= '0;
      k_reg           <= '0;
      num_reg         <= '0;
      seq_reg         <= CNT_WIDTH'(SEQ_START);
      tx_pkt_cnt_reg  <= '0;
      tx_byte_cnt_reg <= '0;
      cycle_cnt_reg   <= '0;
      hdr_data_reg    <= '0;
      hdr_user_reg    <= '0;
      s_ready_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      s_ready_reg <= 1'b1;
      if (state_reg == ST_IDLE && start) begin
        len_reg      <= (pkt_len == 16'd0) ? 16'd1 : pkt_len;
        num_reg      <= num_pkts;
        k_reg        <= '0;
        hdr_data_reg <= hdr_tdata;
        hdr_user_reg <= hdr_tuser;
      end
      if (valid) cycle_cnt_reg <= cycle_cnt_reg + CNT_ONE;
      if (fire) begin
        tx_byte_cnt_reg <= tx_byte_cnt_reg + CNT_WIDTH'(KW);
        if (last_beat) begin
          // Next header is captured here so back-to-back packets need no bubble.
          k_reg          <= '0;
          seq_reg        <= seq_reg + CNT_ONE;
          tx_pkt_cnt_reg <= tx_pkt_cnt_reg + CNT_ONE;
          hdr_data_reg   <= hdr_tdata;
          hdr_user_reg   <= hdr_tuser;
        end else begin
          k_reg <= k_reg + 16'd1;
        end
      end
    end
  end

  assign m_axis_tvalid = valid;
  assign m_axis_tdata  = !valid ? '0 :
                         (k_reg == 16'd0) ? hdr_data_reg :
                         C_AXIS_DATA_WIDTH'(seq_reg + CNT_WIDTH'(k_reg));
  assign m_axis_tuser  = (valid && k_reg == 16'd0) ? hdr_user_reg : '0;
  assign m_axis_tkeep  = valid ? KEEP_ONES : '0;
  assign m_axis_tlast  = valid && last_beat;
  assign s_axis_tready = s_ready_reg;
  assign done          = (state_reg == ST_DONE);
  assign tx_pkt_cnt    = tx_pkt_cnt_reg;
  assign tx_byte_cnt   = tx_byte_cnt_reg;
  assign cycle_cnt     = cycle_cnt_reg;

`ifdef RMT_TRAFFIC_CHECKER_EN
  wire unused_rx = ^s_axis_tuser;

  rmt_traffic_checker #(
    .C_AXIS_DATA_WIDTH (C_AXIS_DATA_WIDTH),
    .CNT_WIDTH         (CNT_WIDTH)
  ) u_checker (
    .clk           (clk),
    .aresetn       (aresetn),
    .rx_len        (len_reg),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_ready_reg),
    .rx_pkt_cnt    (rx_pkt_cnt),
    .err_cnt       (err_cnt)
  );
`else
  // Returned stream is drained but not inspected.
  wire unused_rx = ^{s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast};

  assign rx_pkt_cnt = '0;
  assign err_cnt    = '0;
`endif

endmodule
